// File: rtl/param_shift_rotate_engine.sv
// param_shift_rotate_engine: parametrised multi-cycle shift/rotate register, one bit per clock,
// driven by a start/busy/done handshake.
module param_shift_rotate_engine #(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [AMT_W-1:0] amount,
   input  logic [WIDTH-1:0] data_in,
   input  logic             serial_in,
   output logic [WIDTH-1:0] data_out,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;
   localparam logic [2:0] M_LOAD = 3'd0;
   localparam logic [2:0] M_ROR  = 3'd1;
   localparam logic [2:0] M_ROL  = 3'd2;
   localparam logic [2:0] M_SHR  = 3'd3;
   localparam logic [2:0] M_SHL  = 3'd4;
   localparam logic [2:0] M_ASR  = 3'd5;
   logic [0:0]       state_q, state_d;
   logic [2:0]       mode_q, mode_d;
   logic [AMT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] data_q, data_d, step_data;
   logic             so_q, so_d, step_so;
   logic             done_q, done_d;
   // One single-bit step of the latched operation; reserved modes never reach RUN.
   always_comb begin
      step_data = data_q;
      step_so   = so_q;
      case (mode_q)
         M_ROR: begin step_data = {data_q[0], data_q[WIDTH-1:1]};           step_so = data_q[0];       end
         M_ROL: begin step_data = {data_q[WIDTH-2:0], data_q[WIDTH-1]};     step_so = data_q[WIDTH-1]; end
         M_SHR: begin step_data = {serial_in, data_q[WIDTH-1:1]};           step_so = data_q[0];       end
         M_SHL: begin step_data = {data_q[WIDTH-2:0], serial_in};           step_so = data_q[WIDTH-1]; end
         M_ASR: begin step_data = {data_q[WIDTH-1], data_q[WIDTH-1:1]};     step_so = data_q[0];       end
         default: begin step_data = data_q;                                 step_so = so_q;            end
      endcase
   end
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      count_d = count_q;
      data_d  = data_q;
      so_d    = so_q;
      done_d  = 1'b0;
      if (state_q == IDLE) begin
         if (start) begin
            mode_d  = mode;
            count_d = amount;
            if (mode == M_LOAD) begin
               data_d = data_in;
               done_d = 1'b1;
            end else if (mode > M_ASR || amount == '0) begin
               done_d = 1'b1;
            end else begin
               state_d = RUN;
            end
         end
      end else begin
         data_d  = step_data;
         so_d    = step_so;
         count_d = count_q - AMT_W'(1);
         if (count_q == AMT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mode_q  <= M_LOAD;
         count_q <= '0;
         data_q  <= '0;
         so_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         count_q <= count_d;
         data_q  <= data_d;
         so_q    <= so_d;
         done_q  <= done_d;
      end
   end
   assign data_out   = data_q;
   assign serial_out = so_q;
   assign busy       = (state_q == RUN);
   assign done       = done_q;
endmodule

// File: tb/tb_param_shift_rotate_engine.sv
// tb_param_shift_rotate_engine: random and directed stimulus checked every cycle against
// an arithmetic reference model, plus hand-computed literal results.
module tb_param_shift_rotate_engine;
   localparam int W  = 8;
   localparam int AW = $clog2(W + 1);
   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, serial_in = 1'b0;
   logic [2:0]    mode = 3'd0;
   logic [AW-1:0] amount = '0;
   logic [W-1:0]  data_in = '0;
   logic [W-1:0]  data_out;
   logic          serial_out, busy, done;
   int            n_chk = 0, n_fail = 0;
   bit            chk_on = 1'b0;
   int            e, b;
   always #5 clk = ~clk;
   param_shift_rotate_engine #(.WIDTH(W), .AMT_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .amount(amount),
      .data_in(data_in), .serial_in(serial_in), .data_out(data_out),
      .serial_out(serial_out), .busy(busy), .done(done)
   );
   function automatic logic [W-1:0] step_f(logic [W-1:0] d, logic [2:0] m, logic si);
      case (m)
         3'd1: return (d >> 1) | (d << (W - 1));
         3'd2: return (d << 1) | (d >> (W - 1));
         3'd3: return (d >> 1) | (W'(si) << (W - 1));
         3'd4: return (d << 1) | W'(si);
         3'd5: return W'($signed(d) >>> 1);
         default: return d;
      endcase
   endfunction
   function automatic logic out_f(logic [W-1:0] d, logic [2:0] m);
      return (m == 3'd2 || m == 3'd4) ? d[W-1] : d[0];
   endfunction
   logic [W-1:0] m_data;
   logic         m_so, m_done;
   logic [2:0]   m_mode;
   int           m_rem;
   always @(posedge clk) begin
      if (!rst_n) begin
         m_data <= '0; m_so <= 1'b0; m_done <= 1'b0; m_rem <= 0; m_mode <= 3'd0;
      end else begin
         m_done <= 1'b0;
         if (m_rem == 0) begin
            if (start) begin
               if (mode == 3'd0) begin
                  m_data <= data_in; m_done <= 1'b1;
               end else if (mode > 3'd5 || amount == 0) begin
                  m_done <= 1'b1;
               end else begin
                  m_mode <= mode; m_rem <= int'(amount);
               end
            end
         end else begin
            m_data <= step_f(m_data, m_mode, serial_in);
            m_so   <= out_f(m_data, m_mode);
            m_rem  <= m_rem - 1;
            if (m_rem == 1) m_done <= 1'b1;
         end
      end
   end
   always @(negedge clk) begin
      if (chk_on) begin
         n_chk++;
         if ({data_out, serial_out, busy, done} !== {m_data, m_so, m_rem != 0, m_done}) begin
            n_fail++;
            $display("FAIL model t=%0t: got data=%h so=%b busy=%b done=%b, expected data=%h so=%b busy=%b done=%b",
                     $time, data_out, serial_out, busy, done, m_data, m_so, m_rem != 0, m_done);
         end
      end
   end
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask
   // Starts an operation at the current point (just after an edge) and waits for done.
   task automatic op(input logic [2:0] m, input int a, input logic [W-1:0] d, input int si,
                     input bit dis, output int edges, output int bcnt);
      start = 1'b1; mode = m; amount = AW'(a); data_in = d;
      serial_in = (si > 1) ? 1'($urandom) : si[0];
      @(posedge clk); #1;
      start = 1'b0; edges = 1; bcnt = 0;
      while (!done && edges < 40) begin
         if (busy) bcnt++;
         if (si > 1) serial_in = 1'($urandom);
         if (dis && busy) begin
            start = 1'b1; mode = 3'($urandom); amount = AW'($urandom); data_in = W'($urandom);
         end
         @(posedge clk); #1;
         edges++;
      end
      start = 1'b0;
      if (!done) begin
         n_chk++; n_fail++;
         $display("FAIL timeout: no done after %0d edges", edges);
      end
   endtask
   initial begin
      rst_n = 1'b0; start = 1'b1; data_in = 8'hFF; mode = 3'd0;
      @(posedge clk); #1; chk_on = 1'b1;
      @(posedge clk); #1;
      check("rst_data", 32'(data_out), 32'h00);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_so", 32'(serial_out), 32'h0);
      rst_n = 1'b1; start = 1'b0;
      op(3'd0, 0, 8'hA5, 0, 0, e, b);
      check("load_edges", 32'(e), 32'd1);
      check("load_data", 32'(data_out), 32'hA5);
      op(3'd1, 1, 8'h00, 0, 0, e, b);
      check("ror1_b2b_edges", 32'(e), 32'd2);
      check("ror1_busy", 32'(b), 32'd1);
      check("ror1_data", 32'(data_out), 32'hD2);
      check("ror1_so", 32'(serial_out), 32'h1);
      op(3'd0, 0, 8'h81, 0, 0, e, b);
      op(3'd2, 3, 8'h00, 0, 0, e, b);
      check("rol3_data", 32'(data_out), 32'h0C);
      check("rol3_busy", 32'(b), 32'd3);
      check("rol3_so", 32'(serial_out), 32'h0);
      op(3'd0, 0, 8'h5A, 0, 0, e, b);
      op(3'd1, 8, 8'h00, 0, 0, e, b);
      check("ror8_edges", 32'(e), 32'd9);
      check("ror8_data", 32'(data_out), 32'h5A);
      check("ror8_so", 32'(serial_out), 32'h0);
      op(3'd0, 0, 8'h0F, 0, 0, e, b);
      op(3'd4, 4, 8'h00, 1, 0, e, b);
      check("shl4_data", 32'(data_out), 32'hFF);
      op(3'd0, 0, 8'h90, 0, 0, e, b);
      op(3'd5, 3, 8'h00, 0, 0, e, b);
      check("asr3_data", 32'(data_out), 32'hF2);
      op(3'd0, 0, 8'h03, 0, 0, e, b);
      op(3'd3, 2, 8'h00, 0, 0, e, b);
      check("shr2_data", 32'(data_out), 32'h00);
      check("shr2_so", 32'(serial_out), 32'h1);
      op(3'd0, 0, 8'h3C, 0, 0, e, b);
      op(3'd1, 0, 8'h00, 0, 0, e, b);
      check("amt0_edges", 32'(e), 32'd1);
      check("amt0_data", 32'(data_out), 32'h3C);
      op(3'd6, 3, 8'hFF, 0, 0, e, b);
      check("nop_edges", 32'(e), 32'd1);
      check("nop_data", 32'(data_out), 32'h3C);
      op(3'd0, 0, 8'h01, 0, 0, e, b);
      op(3'd2, 4, 8'h00, 0, 1, e, b);
      check("ignore_start_edges", 32'(e), 32'd5);
      check("ignore_start_data", 32'(data_out), 32'h10);
      op(3'd0, 0, 8'hC3, 0, 0, e, b);
      start = 1'b1; mode = 3'd2; amount = AW'(5);
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("midrst_data", 32'(data_out), 32'h00);
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_done", 32'(done), 32'h0);
      check("midrst_so", 32'(serial_out), 32'h0);
      rst_n = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         check("midrst_nodone", 32'(done), 32'h0);
      end
      repeat (300) begin
         if ($urandom_range(0, 3) == 0) begin
            serial_in = 1'($urandom);
            @(posedge clk); #1;
         end
         op(3'($urandom), $urandom_range(0, 15), W'($urandom), 2, $urandom_range(0, 3) == 0, e, b);
      end
      @(posedge clk); #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
